// File: rtl/mult_share_arbiter_if.sv
// Bundles the requester-side and multiplier-side signals of mult_share_arbiter.
// Directions are named from the arbiter's point of view (slave modport).
interface mult_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic               req0_i;
  logic [WIDTH-1:0]   a0_i;
  logic [WIDTH-1:0]   b0_i;
  logic               req1_i;
  logic [WIDTH-1:0]   a1_i;
  logic [WIDTH-1:0]   b1_i;
  logic               gnt0_o;
  logic               gnt1_o;
  logic               done0_o;
  logic               done1_o;
  logic [2*WIDTH-1:0] prod_o;
  logic               err_o;
  logic               m_start_o;
  logic [WIDTH-1:0]   m_a_o;
  logic [WIDTH-1:0]   m_b_o;
  logic               m_done_i;
  logic [2*WIDTH-1:0] m_prod_i;

  modport slave (
    input  req0_i, a0_i, b0_i, req1_i, a1_i, b1_i, m_done_i, m_prod_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, prod_o, err_o, m_start_o, m_a_o, m_b_o
  );

  modport master (
    output req0_i, a0_i, b0_i, req1_i, a1_i, b1_i, m_done_i, m_prod_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, prod_o, err_o, m_start_o, m_a_o, m_b_o
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one sequential multiplier between two requesters.
// Optional WAIT timeout with err reporting is enabled by defining MULT_TIMEOUT_EN.
module mult_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   m_a_q, m_a_d;
  logic [WIDTH-1:0]   m_b_q, m_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               err_q, err_d;
  logic               m_start_q, m_start_d;

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;
`endif

  // State, operand, result and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      m_a_q     <= '0;
      m_b_q     <= '0;
      prod_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      prod_q    <= prod_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
`ifdef MULT_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    m_a_d   = m_a_q;
    m_b_d   = m_b_q;
    prod_d  = prod_q;
`ifdef MULT_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif

    case (state_q)
      IDLE: begin
        // On a tie, the requester that was not served last wins
        if (bus.req0_i && (!bus.req1_i || last_q)) begin
          owner_d = 1'b0;
          m_a_d   = bus.a0_i;
          m_b_d   = bus.b0_i;
          state_d = LAUNCH;
        end else if (bus.req1_i) begin
          owner_d = 1'b1;
          m_a_d   = bus.a1_i;
          m_b_d   = bus.b1_i;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef MULT_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
      end
      WAIT: begin
        if (bus.m_done_i) begin
          prod_d  = bus.m_prod_i;
          state_d = RESP;
`ifdef MULT_TIMEOUT_EN
        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          prod_d  = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT;
`else
        end else begin
          state_d = WAIT;
`endif
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gnt0_d    = (state_d != IDLE) && !owner_d;
    gnt1_d    = (state_d != IDLE) && owner_d;
    done0_d   = (state_d == RESP) && !owner_d;
    done1_d   = (state_d == RESP) && owner_d;
    m_start_d = (state_d == LAUNCH);
`ifdef MULT_TIMEOUT_EN
    err_d     = (state_d == RESP) && to_d;
`else
    err_d     = 1'b0;
`endif
  end

  assign bus.gnt0_o    = gnt0_q;
  assign bus.gnt1_o    = gnt1_q;
  assign bus.done0_o   = done0_q;
  assign bus.done1_o   = done1_q;
  assign bus.prod_o    = prod_q;
  assign bus.err_o     = err_q;
  assign bus.m_start_o = m_start_q;
  assign bus.m_a_o     = m_a_q;
  assign bus.m_b_o     = m_b_q;

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one sequential 4x4 shift-add multiplier (controller plus datapath) between two requesters.
- Arbitrates with round-robin priority and latches the winner's operands.
- Pulses the multiplier start and waits for its done.
- Returns the product with a one-cycle done pulse to the owning requester.
- Sits between the client blocks and the multiplier top level; the multiplier itself is unchanged.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
TIMEOUT, 16, max cycles in WAIT before abort; used only with MULT_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req0  in  1  requester 0 request; held high until done0.
a0  in  WIDTH  requester 0 multiplicand.
b0  in  WIDTH  requester 0 multiplier.
req1  in  1  requester 1 request.
a1  in  WIDTH  requester 1 multiplicand.
b1  in  WIDTH  requester 1 multiplier.
gnt0  out  1  requester 0 owns the multiplier.
gnt1  out  1  requester 1 owns the multiplier.
done0  out  1  one-cycle pulse: prod valid for requester 0.
done1  out  1  one-cycle pulse: prod valid for requester 1.
prod  out  2*WIDTH  registered result; holds until the next capture.
err  out  1  timeout pulse, coincident with doneX; constant 0 without the macro.
m_start  out  1  one-cycle start pulse to the multiplier.
m_a  out  WIDTH  latched multiplicand to the multiplier.
m_b  out  WIDTH  latched multiplier operand to the multiplier.
m_done  in  1  multiplier finished, level or pulse.
m_prod  in  2*WIDTH  multiplier result, valid when m_done=1.

Behaviour:
Reset:
- rst=0 forces state IDLE asynchronously.
- gnt0, gnt1, done0, done1, err, m_start = 0.
- prod, m_a, m_b = 0; owner=0.
- last=1, so requester 0 wins the first tie.

FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: req sampled only here.
  - Only reqX high: owner=X.
  - Both high: owner = the requester that is not `last`.
  - Latch aX/bX into m_a/m_b, then go to LAUNCH.
  - Neither high: stay in IDLE.
- LAUNCH: m_start=1 for exactly this cycle. m_done is ignored. Next state WAIT.
- WAIT: on m_done=1, register m_prod into prod and go to RESP. Otherwise stay.
- RESP: done<owner>=1 for one cycle; last=owner. Next state IDLE.

Grant and operands:
- gnt<owner>=1 in LAUNCH, WAIT and RESP; both grants are 0 in IDLE.
- gnt0 and gnt1 are never high together.
- m_a/m_b stay stable from LAUNCH through RESP. Changes on aX/bX after latching have no effect.

Latency:
- Request sampled at edge n → m_start high in cycle n+1.
- m_done seen at edge k → doneX high in cycle k+1.
- Minimum 1 IDLE cycle between jobs, so back-to-back jobs alternate when both requesters hold req.

Requester rules:
- A requester keeps req high until its done pulse and drops it the following cycle.
- If req is still high when the arbiter returns to IDLE, it counts as a new request.
- A req that drops while not granted is simply never served; no error.

Reset mid-operation: abandon the job immediately and return to reset values. No done pulse. The multiplier is reset by the same rst.

Optional Feature:
Macro: MULT_TIMEOUT_EN.
- Defined:
  - A log2(TIMEOUT)+1-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with m_done=0: prod=0, go to RESP.
  - RESP asserts doneX and err together for one cycle; last updates normally.
- Undefined: no counter, WAIT waits indefinitely, err tied 0.

Test Plan:
1. req0=1, a0=4'd7, b0=4'd9 (req1=0); model multiplier asserts m_done 6 cycles after m_start → gnt0 high, m_a=7, m_b=9, single m_start pulse, done0 pulse with prod=8'd63, gnt1 never high.
2. req0 and req1 rise same cycle after reset (a0=3,b0=5; a1=15,b1=15), both held → requester 0 served first (prod=15, done0), then requester 1 (prod=225, done1); continued holding alternates 0,1,0,1.
3. Requester 1 served last, then both request → requester 0 wins; requester 0 served last, both request → requester 1 wins.
4. Change a0 to 4'd1 during WAIT (latched a0=12, b0=12) → m_a stays 12, prod=8'd144.
5. rst=0 asserted mid-WAIT → all outputs 0 on the same edge, no done pulse; after release a new req0 runs normally with last=1.
6. MULT_TIMEOUT_EN, TIMEOUT=16, m_done held 0 → exactly 16 WAIT cycles, then done0=1, err=1, prod=0; the next request completes with err=0.
